// File: rtl/rx_lane_am_lock_if.sv
// -----------------------------------------------------------------------------
// rx_lane_am_lock_if
// Lane-word bundle for one receive lane of the AM lock stage.
//   i_valid / i_lane : incoming lane word and its qualifier
//   o_valid / o_lane : the same word one cycle later
//   o_am_flag        : output word sits at the expected AM position
//   o_lock           : lane AM lock achieved
//   o_am_err_cnt     : saturating count of AM mismatches while locked
// Modports: master drives the lane words (upstream / bench);
//           slave is the lock block.
// -----------------------------------------------------------------------------
interface rx_lane_am_lock_if #(
    parameter int LANE_WIDTH    = 1360,
    parameter int ERR_CNT_WIDTH = 16
);
    logic                     i_valid;
    logic [LANE_WIDTH-1:0]    i_lane;
    logic                     o_valid;
    logic [LANE_WIDTH-1:0]    o_lane;
    logic                     o_am_flag;
    logic                     o_lock;
    logic [ERR_CNT_WIDTH-1:0] o_am_err_cnt;

    modport master (
        output i_valid, i_lane,
        input  o_valid, o_lane, o_am_flag, o_lock, o_am_err_cnt
    );

    modport slave (
        input  i_valid, i_lane,
        output o_valid, o_lane, o_am_flag, o_lock, o_am_err_cnt
    );
endinterface

// File: rtl/rx_lane_am_lock.sv
// -----------------------------------------------------------------------------
// rx_lane_am_lock
// Alignment-marker lock for one receive lane (one instance per lane). Hunts
// for the AM, confirms it one period later, then monitors it while locked,
// tagging AM-bearing words and dropping lock after MISS_LIMIT misses in a row.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : rx_lane_am_lock_if.slave (i_valid/i_lane in; o_valid, o_lane,
//          o_am_flag, o_lock, o_am_err_cnt out, all registered, 1-cycle latency)
//
// Build option:
//   RX_AM_LOCK_TOLERANT_EN : when defined, an AM matches with up to 2 bit
//   errors in the AM field; otherwise an exact compare is used.
// -----------------------------------------------------------------------------
module rx_lane_am_lock #(
    parameter int               LANE_WIDTH    = 1360,
    parameter int               AM_WIDTH      = 120,
    parameter logic [AM_WIDTH-1:0] AM_PATTERN = 120'h9A4A26_65B5D9_D94A6B_26B5D9_654A26,
    parameter int               AM_PERIOD     = 4096,
    parameter int               MISS_LIMIT    = 3,
    parameter int               ERR_CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    rx_lane_am_lock_if.slave   bus
);

    localparam int WCNT_W = (AM_PERIOD > 2) ? $clog2(AM_PERIOD) : 1;
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(AM_PERIOD - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t                   r_state;
    logic [WCNT_W-1:0]        r_wcnt;
    logic [MISS_W-1:0]        r_miss;
    logic                     r_valid;
    logic [LANE_WIDTH-1:0]    r_lane;
    logic                     r_am_flag;
    logic                     r_lock;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    state_t                   w_state_nxt;
    logic [WCNT_W-1:0]        w_wcnt_nxt;
    logic [MISS_W-1:0]        w_miss_nxt;
    logic [ERR_CNT_WIDTH-1:0] w_err_nxt;
    logic                     w_am_flag;
    logic                     w_at_am;
    logic                     w_match;

    // -------------------------------------------------------------------------
    // AM detection on the low AM_WIDTH bits of the incoming word
    // -------------------------------------------------------------------------
`ifdef RX_AM_LOCK_TOLERANT_EN
    localparam int POP_W = $clog2(AM_WIDTH + 1);
    logic [AM_WIDTH-1:0] w_diff;
    logic [POP_W-1:0]    w_pop;

    always_comb begin
        w_diff = bus.i_lane[AM_WIDTH-1:0] ^ AM_PATTERN;
        w_pop  = '0;
        for (int k = 0; k < AM_WIDTH; k++) begin
            w_pop = w_pop + POP_W'(w_diff[k]);
        end
    end

    assign w_match = (w_pop <= POP_W'(2));
`else
    assign w_match = (bus.i_lane[AM_WIDTH-1:0] == AM_PATTERN);
`endif

    // wcnt==0 marks the expected AM position once a candidate has been seen
    assign w_at_am = (r_wcnt == '0);

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_miss_nxt  = r_miss;
        w_err_nxt   = r_err_cnt;
        w_am_flag   = 1'b0;

        if (bus.i_valid) begin
            w_wcnt_nxt = (r_wcnt == WCNT_MAX) ? '0 : r_wcnt + 1'b1;

            unique case (r_state)
                ST_SEARCH: begin
                    if (w_match) begin
                        w_state_nxt = ST_VERIFY;
                        w_wcnt_nxt  = WCNT_W'(1);
                        w_am_flag   = 1'b1;
                    end
                end

                ST_VERIFY: begin
                    // A failed confirmation is not re-used as a new candidate.
                    if (w_at_am) begin
                        if (w_match) begin
                            w_state_nxt = ST_LOCKED;
                            w_am_flag   = 1'b1;
                        end else begin
                            w_state_nxt = ST_SEARCH;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (w_at_am) begin
                        w_am_flag = 1'b1;
                        if (w_match) begin
                            w_miss_nxt = '0;
                        end else begin
                            if (r_err_cnt != '1) begin
                                w_err_nxt = r_err_cnt + 1'b1;
                            end
                            if (r_miss == MISS_LAST) begin
                                w_state_nxt = ST_SEARCH;
                                w_miss_nxt  = '0;
                            end else begin
                                w_miss_nxt = r_miss + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_SEARCH;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            r_state   <= ST_SEARCH;
            r_wcnt    <= '0;
            r_miss    <= '0;
            r_valid   <= 1'b0;
            // NOTE: the wide lane register is reset too because o_lane is an
            // output whose reset value is defined as zero.
            r_lane    <= '0;
            r_am_flag <= 1'b0;
            r_lock    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_miss    <= w_miss_nxt;
            r_err_cnt <= w_err_nxt;
            r_valid   <= bus.i_valid;
            r_am_flag <= w_am_flag;
            // Lock is reported together with the word that changed it.
            r_lock    <= (w_state_nxt == ST_LOCKED);
            if (bus.i_valid) begin
                r_lane <= bus.i_lane;
            end
        end
    end

    assign bus.o_valid      = r_valid;
    assign bus.o_lane       = r_lane;
    assign bus.o_am_flag    = r_am_flag;
    assign bus.o_lock       = r_lock;
    assign bus.o_am_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_rx_lane_am_lock.sv
// -----------------------------------------------------------------------------
// tb_rx_lane_am_lock
// Scoreboard bench for rx_lane_am_lock with AM_PERIOD=8. Stimulus pushes the
// hand-computed flag/lock/error-count expectation of every valid word; a
// monitor pops on each o_valid and also follows o_valid/o_lane latency.
// -----------------------------------------------------------------------------
module tb_rx_lane_am_lock;

    localparam int LW     = 1360;
    localparam int AMW    = 120;
    localparam int PERIOD = 8;
    localparam int ECW    = 16;
    localparam logic [AMW-1:0] AM_PAT = 120'h9A4A26_65B5D9_D94A6B_26B5D9_654A26;

    typedef enum int { W_RAND, W_CLEAN, W_ONEBIT, W_ZERO } wkind_t;

    typedef struct {
        int             idx;
        logic           flag;
        logic           lock;
        logic [ECW-1:0] err;
    } exp_t;

    logic clk;
    logic rst;

    rx_lane_am_lock_if #(.LANE_WIDTH(LW), .ERR_CNT_WIDTH(ECW)) bus ();

    rx_lane_am_lock #(
        .LANE_WIDTH   (LW),
        .AM_WIDTH     (AMW),
        .AM_PATTERN   (AM_PAT),
        .AM_PERIOD    (PERIOD),
        .MISS_LIMIT   (3),
        .ERR_CNT_WIDTH(ECW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t           q[$];
    int             n_checks = 0;
    int             n_errors = 0;
    logic [AMW-1:0] am_pat   = AM_PAT;
    logic           exp_valid;
    logic [LW-1:0]  exp_lane;
    logic           mon_en = 1'b0;
`ifdef RX_AM_LOCK_TOLERANT_EN
    int             err_base = 0;
`else
    int             err_base = 1;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Random lane word whose low byte is the inverse of the AM low byte, so it
    // differs from the AM in at least 8 bits and never matches.
    function automatic logic [LW-1:0] make_word(input wkind_t kind);
        logic [LW-1:0] w;
        for (int i = 0; i < LW; i++) w[i] = 1'($urandom);
        case (kind)
            W_CLEAN:  w[AMW-1:0] = am_pat;
            W_ONEBIT: w[AMW-1:0] = am_pat ^ {{(AMW-1){1'b0}}, 1'b1};
            W_ZERO:   w[AMW-1:0] = '0;
            default:  w[7:0]     = ~am_pat[7:0];
        endcase
        return w;
    endfunction

    task automatic send(input int idx, input wkind_t kind, input logic flag,
                        input logic lock, input int err);
        exp_t e;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b1;
        bus.i_lane  = make_word(kind);
        e.idx  = idx;
        e.flag = flag;
        e.lock = lock;
        e.err  = ECW'(err);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.i_valid = 1'b0;
            bus.i_lane  = make_word(W_RAND);
        end
    endtask

    // Latency model for o_valid / o_lane: one cycle, lane holds across gaps.
    always @(posedge clk) begin
        exp_valid <= rst & bus.i_valid;
        if (!rst)             exp_lane <= '0;
        else if (bus.i_valid) exp_lane <= bus.i_lane;
        mon_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("o_valid", 64'(bus.o_valid), 64'(exp_valid));
            n_checks++;
            if (bus.o_lane !== exp_lane) begin
                n_errors++;
                $display("FAIL o_lane: got low %h expected low %h",
                         bus.o_lane[63:0], exp_lane[63:0]);
            end
            if (bus.o_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got o_valid=1 expected no word");
                end else begin
                    e = q.pop_front();
                    check($sformatf("o_am_flag w%0d", e.idx), 64'(bus.o_am_flag), 64'(e.flag));
                    check($sformatf("o_lock w%0d", e.idx), 64'(bus.o_lock), 64'(e.lock));
                    check($sformatf("o_am_err_cnt w%0d", e.idx), 64'(bus.o_am_err_cnt), 64'(e.err));
                end
            end else begin
                check("o_am_flag idle", 64'(bus.o_am_flag), 64'd0);
            end
        end
    end

    initial begin
        int     err;
        logic   lock;
        wkind_t kind;

        // 1. Reset held low while valid random words arrive.
        rst         = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_lane  = make_word(W_RAND);
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.i_lane = make_word(W_RAND);
            @(negedge clk);
            check("reset o_lock", 64'(bus.o_lock), 64'd0);
            check("reset o_am_flag", 64'(bus.o_am_flag), 64'd0);
            check("reset o_am_err_cnt", 64'(bus.o_am_err_cnt), 64'd0);
        end
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.i_valid = 1'b0;

        // 2. Clean stream: candidate at 0, lock with word 8.
        for (int i = 0; i < 24; i++) begin
            send(i, (i % PERIOD == 0) ? W_CLEAN : W_RAND, i % PERIOD == 0, i >= 8, 0);
        end

        // 3. Single-bit corrupted AM at word 24, clean again at 32.
        for (int i = 24; i < 40; i++) begin
            kind = (i == 24) ? W_ONEBIT : ((i == 32) ? W_CLEAN : W_RAND);
            send(i, kind, i % PERIOD == 0, 1'b1, err_base);
        end

        // 4. Three zeroed AMs (40, 48, 56) drop lock; clean AMs at 64, 72 relock.
        for (int i = 40; i < 80; i++) begin
            if (i == 40 || i == 48 || i == 56)  kind = W_ZERO;
            else if (i == 64 || i == 72)        kind = W_CLEAN;
            else                                kind = W_RAND;
            err  = err_base + 1 + (i >= 48 ? 1 : 0) + (i >= 56 ? 1 : 0);
            lock = (i < 56) || (i >= 72);
            send(i, kind, i % PERIOD == 0, lock, err);
        end

        // 5. Locked with 5 idle cycles after each valid word.
        for (int i = 80; i <= 96; i++) begin
            send(i, (i % PERIOD == 0) ? W_CLEAN : W_RAND, i % PERIOD == 0, 1'b1, err_base + 3);
            idle(5);
        end

        // 6. Reset pulse while locked, then reacquire from scratch.
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_lane  = make_word(W_CLEAN);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        check("pulse o_lock", 64'(bus.o_lock), 64'd0);
        check("pulse o_am_err_cnt", 64'(bus.o_am_err_cnt), 64'd0);
        check("pulse o_am_flag", 64'(bus.o_am_flag), 64'd0);
        for (int i = 0; i < 13; i++) begin
            // AM candidates at local word 3 and 11.
            kind = (i == 3 || i == 11) ? W_CLEAN : W_RAND;
            send(200 + i, kind, i == 3 || i == 11, i >= 11, 0);
        end
        idle(1);

        repeat (4) @(negedge clk);
        check("queue drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_lane_am_lock.md
Name: rx_lane_am_lock

Overview:
Receive-side counterpart of the TX lane distribution stage. It sits on one physical lane ahead of deskew and RS decode, and one instance is used per lane (16 total).
- Hunts for the alignment marker (AM) in the lane word stream.
- Confirms the AM at the expected period, then declares lock.
- Monitors AMs once locked, tagging AM-bearing words and dropping lock after repeated misses.

Parameters:
LANE_WIDTH, 1360, width of one lane word
AM_WIDTH, 120, AM field width, located at bits [AM_WIDTH-1:0] of an AM-bearing word
AM_PATTERN, 120'h9A4A26_65B5D9_D94A6B_26B5D9_654A26 (lane-0 AM), expected AM value
AM_PERIOD, 4096, valid lane words from one AM to the next (>=2)
MISS_LIMIT, 3, consecutive AM mismatches in LOCKED that force loss of lock
ERR_CNT_WIDTH, 16, width of the AM error counter

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous, active-low reset (rst==0 resets on clk edge)
i_valid  in  1  lane word qualifier
i_lane  in  LANE_WIDTH  received lane word
o_valid  out  1  i_valid delayed 1 cycle
o_lane  out  LANE_WIDTH  i_lane delayed 1 cycle
o_am_flag  out  1  with o_valid: this word sits at the expected AM position
o_lock  out  1  lane AM lock achieved
o_am_err_cnt  out  ERR_CNT_WIDTH  saturating count of AM mismatches while LOCKED

Behaviour:
- All outputs are registered. Latency is 1 cycle from i_lane/i_valid to o_lane/o_valid/o_am_flag.
- Reset value is 0 for every output. State is SEARCH, word counter = 0, miss counter = 0.
- match = (i_lane[AM_WIDTH-1:0] == AM_PATTERN). It is evaluated only when i_valid=1.
- When i_valid=0:
  - state and all counters hold;
  - o_valid=0 and o_am_flag=0;
  - o_lane holds its previous value.
- Word counter wcnt:
  - counts valid words since the last AM position, range 0..AM_PERIOD-1;
  - set to 1 on the word that starts VERIFY;
  - otherwise increments per valid word and wraps to 0 after AM_PERIOD-1;
  - expected AM position means wcnt==0 in VERIFY or LOCKED.
- State SEARCH:
  - o_lock=0.
  - Every valid word is checked.
  - match -> VERIFY, wcnt=1. That word gets o_am_flag=1 (candidate).
- State VERIFY:
  - Non-AM positions are ignored.
  - At the expected position: match -> LOCKED, o_am_flag=1, o_lock=1 registered with that word's output.
  - At the expected position: mismatch -> SEARCH, o_am_flag=0. The mismatching word is not re-tested as a new candidate.
- State LOCKED:
  - o_lock=1.
  - o_am_flag=1 on every expected-position word, regardless of match.
  - match -> miss counter cleared.
  - mismatch -> o_am_err_cnt+1, saturating at all-ones; miss counter +1.
  - When the miss counter reaches MISS_LIMIT -> SEARCH. o_lock=0 is registered with that same word's output. The miss counter clears.
- o_am_err_cnt is cleared only by reset. It is not cleared on loss of lock.
- A reset asserted mid-stream takes priority over i_valid. On the next edge, state is SEARCH and all outputs are 0.

Optional Feature:
Macro RX_AM_LOCK_TOLERANT_EN.
- Defined: match = popcount(i_lane[AM_WIDTH-1:0] ^ AM_PATTERN) <= 2. The popcount is combinational; latency is unchanged.
- Not defined: exact-compare only, no popcount logic is synthesized.

Test Plan:
1. Reset with rst=0 for 3 cycles while random words are driven with i_valid=1 -> all outputs 0, o_lock=0.
2. AM_PERIOD=8, clean stream with the AM at words 0, 8, 16, ... ->
   - word 0: o_am_flag=1, o_lock=0;
   - word 8: o_am_flag=1, o_lock=1 on the same output cycle;
   - afterwards: o_am_flag on every 8th word, o_am_err_cnt=0.
3. Locked with AM_PERIOD=8, AM at word 24 corrupted in 1 bit -> o_lock stays 1, o_am_flag=1 on word 24, o_am_err_cnt=1. With RX_AM_LOCK_TOLERANT_EN defined -> o_am_err_cnt stays 0.
4. Locked, AMs at words 24, 32 and 40 replaced with zeros ->
   - o_lock falls with word 40's output and o_am_err_cnt=3;
   - a clean AM at word 48 -> VERIFY; word 56 -> o_lock=1 again.
5. Locked, i_valid=0 for 5 cycles between each valid word -> o_valid/o_am_flag stay 0 during gaps, the AM is still flagged every 8 valid words, o_lock stays 1.
6. Reset pulse while LOCKED -> next cycle o_lock=0, o_am_err_cnt=0. The first subsequent AM starts VERIFY again.
